// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-access stage behind the execute-stage ALU. Accepts one load or store
// at a time, issues it on a 64-bit valid/ready data-memory port, and returns
// a registered, sign- or zero-extended load result. Illegal or misaligned
// requests never reach memory; they raise a one-cycle exception pulse instead.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_*              request from execute stage (valid/ready handshake)
//   mem_req_*, mem_we,
//   mem_addr/wdata/wstrb  request to data memory (valid/ready handshake)
//   mem_rsp_valid,
//   mem_rdata          response/acknowledge from data memory
//   wb_valid/rd/data   one-cycle load write-back
//   misaligned_exc,
//   illegal_exc        one-cycle exception pulses
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int XLEN          = 64,
  parameter int FUNCT3_SIZE   = 3,
  parameter int REG_ADDR_SIZE = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // execute-stage request
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_is_store,
  input  logic [FUNCT3_SIZE-1:0]   req_funct3,
  input  logic [XLEN-1:0]          req_addr,
  input  logic [XLEN-1:0]          req_store_data,
  input  logic [REG_ADDR_SIZE-1:0] req_rd,
  // data-memory port
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_we,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [XLEN/8-1:0]        mem_wstrb,
  input  logic                     mem_rsp_valid,
  input  logic [XLEN-1:0]          mem_rdata,
  // write-back
  output logic                     wb_valid,
  output logic [REG_ADDR_SIZE-1:0] wb_rd,
  output logic [XLEN-1:0]          wb_data,
  // exceptions
  output logic                     misaligned_exc,
  output logic                     illegal_exc
);

  localparam int STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [2:0]        off;
  logic              illegal;
  logic              misaligned;
  logic              accept;
  logic              start;
  logic [STRB_W-1:0] size_mask;
  logic [XLEN-1:0]   shifted_wdata;
  logic [STRB_W-1:0] shifted_wstrb;

  assign off    = req_addr[2:0];
  assign accept = req_valid && req_ready;
  // Only a legal, aligned request starts a memory transaction.
  assign start  = accept && !illegal && !misaligned;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    illegal    = (req_funct3 == 3'b111) || (req_is_store && req_funct3[2]);
    misaligned = 1'b0;
    size_mask  = STRB_W'(8'h01);
    unique case (req_funct3[1:0])
      2'b00: begin
        misaligned = 1'b0;
        size_mask  = STRB_W'(8'h01);
      end
      2'b01: begin
        misaligned = off[0];
        size_mask  = STRB_W'(8'h03);
      end
      2'b10: begin
        misaligned = |off[1:0];
        size_mask  = STRB_W'(8'h0F);
      end
      default: begin
        misaligned = |off;
        size_mask  = STRB_W'(8'hFF);
      end
    endcase
  end

  // Aligned accesses never cross the doubleword, so the strobe shift cannot
  // overflow the lane mask.
  assign shifted_wdata = req_store_data << {off, 3'b000};
  assign shifted_wstrb = size_mask << off;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)         state_d = S_REQ;
      S_REQ:   if (mem_req_ready) state_d = S_WAIT;
      // A response in the handshake cycle itself is still in S_REQ and is
      // therefore ignored; only S_WAIT listens to mem_rsp_valid.
      S_WAIT:  if (mem_rsp_valid) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // req_ready is held low while reset is asserted so every output reads 0.
  always_comb begin
    req_ready     = rst_n && (state_q == S_IDLE);
    mem_req_valid = (state_q == S_REQ);
  end

  // ---------------------------------------------------------------------------
  // Latched transaction and write-back datapath
  // ---------------------------------------------------------------------------
  logic                     we_q;
  logic [XLEN-1:0]          addr_q;
  logic [XLEN-1:0]          wdata_q;
  logic [STRB_W-1:0]        wstrb_q;
  logic [2:0]               off_q;
  logic [FUNCT3_SIZE-1:0]   funct3_q;
  logic [REG_ADDR_SIZE-1:0] rd_q;
  logic                     wb_valid_q;
  logic [REG_ADDR_SIZE-1:0] wb_rd_q;
  logic [XLEN-1:0]          wb_data_q;
  logic                     misaligned_q;
  logic                     illegal_q;
  logic                     load_done;
  logic [XLEN-1:0]          rdata_shifted;
  logic [XLEN-1:0]          load_ext;

  assign load_done     = (state_q == S_WAIT) && mem_rsp_valid && !we_q;
  assign rdata_shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = rdata_shifted;
    unique case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){rdata_shifted[7]}},   rdata_shifted[7:0]};
      3'b001:  load_ext = {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b010:  load_ext = {{(XLEN-32){rdata_shifted[31]}}, rdata_shifted[31:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}},               rdata_shifted[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}},              rdata_shifted[15:0]};
      3'b110:  load_ext = {{(XLEN-32){1'b0}},              rdata_shifted[31:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  // NOTE: all datapath registers are reset too, because every one of them
  // drives a port that must read 0 during and right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      off_q        <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      // Exceptions are single-cycle pulses; illegal wins over misaligned.
      illegal_q    <= accept && illegal;
      misaligned_q <= accept && !illegal && misaligned;
      wb_valid_q   <= load_done;

      if (start) begin
        we_q     <= req_is_store;
        addr_q   <= {req_addr[XLEN-1:3], 3'b000};
        wdata_q  <= req_is_store ? shifted_wdata : '0;
        wstrb_q  <= req_is_store ? shifted_wstrb : '0;
        off_q    <= off;
        funct3_q <= req_funct3;
        rd_q     <= req_rd;
      end

      if (load_done) begin
        wb_data_q <= load_ext;
        wb_rd_q   <= rd_q;
      end
    end
  end

  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wstrb      = wstrb_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign misaligned_exc = misaligned_q;
  assign illegal_exc    = illegal_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed, self-checking bench for load_store_unit. Inputs change and
// outputs are sampled on the falling clock edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_store_data;
  logic [4:0]  req_rd;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        misaligned_exc;
  logic        illegal_exc;

  int checks   = 0;
  int failures = 0;

  load_store_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_store_data (req_store_data),
    .req_rd         (req_rd),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rdata      (mem_rdata),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .misaligned_exc (misaligned_exc),
    .illegal_exc    (illegal_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request for one cycle; returns at the falling edge of cycle 1.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] data, input logic [4:0] rd);
    req_valid      = 1'b1;
    req_is_store   = st;
    req_funct3     = f3;
    req_addr       = addr;
    req_store_data = data;
    req_rd         = rd;
    step();
    req_valid      = 1'b0;
    req_addr       = 64'hFFFF_FFFF_FFFF_FFFF;
    req_store_data = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic handshake();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [63:0] rdata);
    mem_rsp_valid = 1'b1;
    mem_rdata     = rdata;
    step();
    mem_rsp_valid = 1'b0;
    mem_rdata     = 64'h0;
  endtask

  initial begin
    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_is_store   = 1'b0;
    req_funct3     = 3'b000;
    req_addr       = 64'h0;
    req_store_data = 64'h0;
    req_rd         = 5'd0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rdata      = 64'h0;

    // ---------------- reset state ----------------
    step();
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_exc", {misaligned_exc, illegal_exc}, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_req_ready", req_ready, 1);

    // ---------------- LB 0x1003 ----------------
    issue(1'b0, 3'b000, 64'h1003, 64'h0, 5'd5);
    check("lb_mem_req_valid", mem_req_valid, 1);
    check("lb_mem_addr", mem_addr, 64'h1000);
    check("lb_wstrb", mem_wstrb, 8'h00);
    check("lb_we", mem_we, 0);
    check("lb_req_ready_busy", req_ready, 0);
    handshake();
    check("lb_wait_valid_low", mem_req_valid, 0);
    respond(64'h0000_0000_8000_0000);
    check("lb_wb_valid", wb_valid, 1);
    check("lb_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_wb_rd", wb_rd, 5);
    check("lb_req_ready_back", req_ready, 1);

    // ---------------- LWU then LW back-to-back ----------------
    issue(1'b0, 3'b110, 64'h2004, 64'h0, 5'd6);
    check("lb_wb_pulse_end", wb_valid, 0);
    check("lwu_mem_addr", mem_addr, 64'h2000);
    handshake();
    respond(64'hDEAD_BEEF_0000_0000);
    check("lwu_wb_valid", wb_valid, 1);
    check("lwu_wb_data", wb_data, 64'h0000_0000_DEAD_BEEF);
    // new request accepted on the edge that ends this wb_valid cycle
    issue(1'b0, 3'b010, 64'h2004, 64'h0, 5'd7);
    check("lw_b2b_req_valid", mem_req_valid, 1);
    check("lw_b2b_wb_end", wb_valid, 0);
    handshake();
    respond(64'hDEAD_BEEF_0000_0000);
    check("lw_wb_data", wb_data, 64'hFFFF_FFFF_DEAD_BEEF);
    check("lw_wb_rd", wb_rd, 7);

    // ---------------- SH 0x3006 ----------------
    step();
    issue(1'b1, 3'b001, 64'h3006, 64'h0000_0000_0000_1234, 5'd9);
    check("sh_mem_addr", mem_addr, 64'h3000);
    check("sh_wdata", mem_wdata, 64'h1234_0000_0000_0000);
    check("sh_wstrb", mem_wstrb, 8'hC0);
    check("sh_we", mem_we, 1);
    handshake();
    respond(64'h0);
    check("sh_no_wb", wb_valid, 0);
    check("sh_req_ready_back", req_ready, 1);

    // ---------------- misaligned LW ----------------
    issue(1'b0, 3'b010, 64'h4002, 64'h0, 5'd3);
    check("mis_exc", misaligned_exc, 1);
    check("mis_no_illegal", illegal_exc, 0);
    check("mis_no_mem", mem_req_valid, 0);
    check("mis_req_ready", req_ready, 1);
    step();
    check("mis_pulse_end", misaligned_exc, 0);
    check("mis_no_mem2", mem_req_valid, 0);
    check("mis_no_wb", wb_valid, 0);

    // ---------------- illegal store funct3=100 ----------------
    issue(1'b1, 3'b100, 64'h5000, 64'h55, 5'd3);
    check("ill_st_exc", illegal_exc, 1);
    check("ill_st_no_mis", misaligned_exc, 0);
    check("ill_st_no_mem", mem_req_valid, 0);
    // funct3=111 load, also misaligned: illegal has priority
    issue(1'b0, 3'b111, 64'h5001, 64'h0, 5'd3);
    check("ill_ld_exc", illegal_exc, 1);
    check("ill_ld_no_mis", misaligned_exc, 0);
    step();
    check("ill_pulse_end", illegal_exc, 0);

    // ---------------- backpressure, response delay, back-to-back LD ----------------
    issue(1'b0, 3'b011, 64'h6000, 64'h0, 5'd11);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", mem_req_valid, 1);
      check("bp_addr_held", mem_addr, 64'h6000);
      check("bp_strb_we_held", {mem_we, mem_wstrb}, 9'h000);
      check("bp_wdata_held", mem_wdata, 64'h0);
      step();
    end
    // handshake with a simultaneous (ignored) response
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("dly_wait_no_valid", mem_req_valid, 0);
      check("dly_no_wb", wb_valid, 0);
      check("dly_not_ready", req_ready, 0);
      step();
    end
    respond(64'h0123_4567_89AB_CDEF);
    check("ld1_wb_valid", wb_valid, 1);
    check("ld1_wb_data", wb_data, 64'h0123_4567_89AB_CDEF);
    check("ld1_wb_rd", wb_rd, 11);
    issue(1'b0, 3'b011, 64'h6008, 64'h0, 5'd12);
    check("ld2_mem_addr", mem_addr, 64'h6008);
    handshake();
    respond(64'hFEDC_BA98_7654_3210);
    check("ld2_wb_valid", wb_valid, 1);
    check("ld2_wb_data", wb_data, 64'hFEDC_BA98_7654_3210);
    check("ld2_wb_rd", wb_rd, 12);

    // ---------------- reset mid-operation ----------------
    step();
    issue(1'b0, 3'b000, 64'h7001, 64'h0, 5'd9);
    handshake();
    check("mid_in_wait", {mem_req_valid, req_ready}, 2'b00);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_mem_valid", mem_req_valid, 0);
    check("mid_rst_mem_addr", mem_addr, 64'h0);
    check("mid_rst_wb", {wb_valid, wb_data}, 65'h0);
    check("mid_rst_exc", {misaligned_exc, illegal_exc}, 0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    rst_n         = 1'b1;
    mem_rsp_valid = 1'b0;
    step();
    check("mid_rel_no_wb", wb_valid, 0);
    check("mid_rel_ready", req_ready, 1);
    issue(1'b0, 3'b101, 64'h7002, 64'h0, 5'd10);
    check("mid_next_addr", mem_addr, 64'h7000);
    handshake();
    respond(64'h0000_0000_ABCD_0000);
    check("mid_next_wb_valid", wb_valid, 1);
    check("mid_next_lhu", wb_data, 64'h0000_0000_0000_ABCD);
    check("mid_next_rd", wb_rd, 10);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the execute-stage ALU: takes the ALU's effective address plus the operation's width/sign and store data, and performs one load or store per request on a 64-bit data-memory port with a valid/ready handshake. It computes byte lanes and strobes, sign- or zero-extends load data, and returns a registered write-back result. It raises a one-cycle exception pulse for misaligned or illegal accesses.

## Interface
- XLEN, 64: data, address and memory-bus width; strobe width is XLEN/8.
- FUNCT3_SIZE, 3: width of the access-type field.
- REG_ADDR_SIZE, 5: destination-register index width.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  execute stage presents a memory operation.
- req_ready  out  1  combinational; high only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  access type:
  - 000 B, 001 H, 010 W, 011 D
  - 100 BU, 101 HU, 110 WU
- req_addr  in  XLEN  effective address (ALU data_out).
- req_store_data  in  XLEN  store source data, right-aligned.
- req_rd  in  5  load destination register.
- mem_req_valid  out  1  memory request pending.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  write enable.
- mem_addr  out  XLEN  doubleword-aligned address: {addr[XLEN-1:3], 3'b000}.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wstrb  out  XLEN/8  byte strobes.
- mem_rsp_valid  in  1  response or acknowledge for the outstanding request.
- mem_rdata  in  XLEN  read data, valid with mem_rsp_valid.
- wb_valid  out  1  one-cycle pulse: load result valid.
- wb_rd  out  5  destination register for wb_data.
- wb_data  out  XLEN  extended load result.
- misaligned_exc  out  1  one-cycle pulse.
- illegal_exc  out  1  one-cycle pulse.

## Operation
- **Acceptance.** A request is accepted on an edge where req_valid && req_ready. All request fields are latched at that edge and are don't-care afterwards.
- **Byte offset and size.** off = req_addr[2:0]; size = 1/2/4/8 bytes for funct3[1:0] = 00/01/10/11.
- **Illegal.** Stores with funct3[2]=1, and funct3 = 111, are illegal.
- **Misaligned.** H needs off[0]=0; W needs off[1:0]=0; D needs off=0.
- **States:** IDLE, REQ, WAIT.
  - IDLE → REQ on accepting a legal, aligned request.
  - IDLE → IDLE on accepting an illegal or misaligned request. The matching exc pulses on the next cycle; there is no memory access and no wb_valid. Illegal takes priority over misaligned.
  - REQ: mem_req_valid=1 with mem_we, mem_addr, mem_wdata and mem_wstrb held stable. REQ → WAIT on mem_req_ready.
  - WAIT: mem_req_valid=0. WAIT → IDLE on mem_rsp_valid.
- **Store.** mem_wdata = req_store_data << (8·off); mem_wstrb = ((1<<size)-1) << off; the store completes on mem_rsp_valid.
- **Load.**
  - mem_wstrb = 0.
  - On mem_rsp_valid: wb_data = (mem_rdata >> 8·off), truncated to size. It is sign-extended for B/H/W/D and zero-extended for BU/HU/WU.
  - wb_data and wb_rd are registered; wb_valid pulses for exactly one cycle.
- **Ignored inputs.** mem_rsp_valid outside WAIT is ignored. mem_req_ready outside REQ is ignored.
- **Single outstanding.** At most one transaction is outstanding; req_ready=0 in REQ and WAIT.

## Timing
- **Reset values.** All outputs 0 and state IDLE; req_ready=1 once rst_n is high.
- **Reset mid-operation.** Assertion at any point abandons the transaction with no wb_valid and no exc. The memory side is reset by the same rst_n.
- **Best-case load.**
  - Accept at edge 0; mem_req_valid high during cycle 1, handshake at edge 1.
  - mem_rsp_valid during cycle 2.
  - wb_valid high during cycle 3.
- **Back-to-back.** req_ready is high again in cycle 3, so a new request can be accepted at the same edge that ends the wb_valid cycle.
- **Stalls.** mem_req_ready low holds REQ with outputs unchanged. Arbitrary response delay holds WAIT.
- **Exceptions.** An exc pulse appears the cycle after acceptance; req_ready stays 1 throughout.
- **Simultaneous handshake and response.** mem_req_ready and mem_rsp_valid in the same REQ cycle: the response is ignored, because a response is only legal from the cycle after the request handshake.

## Test plan
- **Load, signed byte.** LB, addr=0x1003, mem_rdata=0x0000_0000_8000_0000 → mem_addr=0x1000, wstrb=0x00, wb_data=0xFFFF_FFFF_FFFF_FF80, wb_valid in cycle 3.
- **Load, unsigned word.** LWU, addr=0x2004, mem_rdata=0xDEAD_BEEF_0000_0000 → wb_data=0x0000_0000_DEAD_BEEF; LW from the same data → 0xFFFF_FFFF_DEAD_BEEF.
- **Store half.** SH, addr=0x3006, data=0x1234 → mem_wdata=0x1234_0000_0000_0000, mem_wstrb=0xC0, mem_we=1, no wb_valid.
- **Misaligned and illegal.** LW at addr 0x4002 → misaligned_exc 1-cycle pulse, mem_req_valid never high. Store with funct3=100 → illegal_exc only.
- **Backpressure and back-to-back.**
  - Drive mem_req_ready low for 5 cycles: mem_* outputs stay stable throughout.
  - Delay the response by 3 cycles.
  - Issue a second LD the cycle req_ready returns high: both results are correct and in order.
- **Reset mid-operation.** Drop rst_n while in WAIT → all outputs 0 immediately, no wb_valid after release, next request executes normally.
